lfsr_checker: RTL and testbench

Receive-side checker for the 4-bit maximal-length LFSR stream (x^4 + x^3 + 1, period 15) produced by the on-chip random generator. It self-synchronises to an incoming sample stream, declares lock after a run of correct predictions, and then counts and flags prediction errors. It sits on the generator's raw LFSR output path and is used for board-level self-test and verification of the randomness source.

---
 rtl/lfsr_checker.sv | 129 ++++++++++++
 tb/tb_lfsr_checker.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// Receive-side checker for the x^4+x^3+1 LFSR stream: self-synchronises, locks
// after a run of correct predictions, then counts and flags mispredictions.
module lfsr_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [3:0]       in_data,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             zero_seen
);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

  state_t     state, state_next;
  logic [3:0] expected, expected_next;
  logic [3:0] match_cnt, match_next;
  logic [3:0] miss_cnt, miss_next;
  logic       err_hit, zero_hit;
  logic       is_zero, is_match;

  function automatic logic [3:0] nxt(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  assign is_zero  = (in_data == 4'd0);
  assign is_match = (in_data == expected);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= HUNT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (in_valid) begin
      case (state)
        HUNT:    if (!is_zero) state_next = VERIFY;
        VERIFY: begin
          if (is_match) begin
            if (match_cnt + 4'd1 == LOCK_N) state_next = LOCKED;
          end else if (is_zero) begin
            state_next = HUNT;
          end
        end
        LOCKED:  if (!is_match && (miss_cnt + 4'd1 == LOSS_N)) state_next = HUNT;
        default: state_next = HUNT;
      endcase
    end
  end

  // In LOCKED the prediction free-runs and is never reseeded from the data,
  // so a single corrupt sample costs exactly one error.
  always_comb begin
    expected_next = expected;
    match_next    = match_cnt;
    miss_next     = miss_cnt;
    err_hit       = 1'b0;
    zero_hit      = 1'b0;
    if (in_valid) begin
      case (state)
        HUNT: begin
          if (is_zero) begin
            zero_hit = 1'b1;
          end else begin
            expected_next = nxt(in_data);
            match_next    = 4'd0;
          end
        end
        VERIFY: begin
          if (is_match) begin
            expected_next = nxt(expected);
            match_next    = match_cnt + 4'd1;
            if (match_cnt + 4'd1 == LOCK_N) miss_next = 4'd0;
          end else if (is_zero) begin
            zero_hit = 1'b1;
          end else begin
            expected_next = nxt(in_data);
            match_next    = 4'd0;
          end
        end
        LOCKED: begin
          expected_next = nxt(expected);
          if (is_match) begin
            miss_next = 4'd0;
          end else begin
            err_hit   = 1'b1;
            zero_hit  = is_zero;
            miss_next = miss_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // clear wins over a same-cycle increment or zero detection, but not over err_pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      expected  <= 4'd0;
      match_cnt <= 4'd0;
      miss_cnt  <= 4'd0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      zero_seen <= 1'b0;
    end else begin
      expected  <= expected_next;
      match_cnt <= match_next;
      miss_cnt  <= miss_next;
      locked    <= (state_next == LOCKED);
      err_pulse <= err_hit;
      if (clear)                       err_count <= '0;
      else if (err_hit && !(&err_count)) err_count <= err_count + 1'b1;
      if (clear)         zero_seen <= 1'b0;
      else if (zero_hit) zero_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: directed vectors push expected outputs,
// a negedge monitor pops and compares them.
module tb_lfsr_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       clear = 1'b0;
  logic       locked, err_pulse, zero_seen;
  logic [7:0] err_count;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic       l;
    logic       p;
    logic [7:0] c;
    logic       z;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  lfsr_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .clear(clear), .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count), .zero_seen(zero_seen)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] gen_next(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  function automatic logic [3:0] wrong_val(input logic [3:0] s);
    return (s == 4'h6) ? 4'h1 : (s ^ 4'h6);
  endfunction

  task automatic check_field(input string tag, input string field,
                             input int actual, input int required);
    total++;
    if (actual != required) begin
      bad++;
      $display("[TB] FAIL %s.%s actual=%0d required=%0d", tag, field, actual, required);
    end
  endtask

  task automatic check_output(input string tag, input logic l, input logic p,
                              input logic [7:0] c, input logic z);
    check_field(tag, "locked", locked, l);
    check_field(tag, "err_pulse", err_pulse, p);
    check_field(tag, "err_count", err_count, c);
    check_field(tag, "zero_seen", zero_seen, z);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_output(mon_e.tag, mon_e.l, mon_e.p, mon_e.c, mon_e.z);
    end
  end

  task automatic apply_stimulus(input logic v, input logic [3:0] d, input logic c,
                                input logic l, input logic p, input logic [7:0] cnt,
                                input logic z, input string tag);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    clear    = c;
    @(posedge clk);
    e.l = l; e.p = p; e.c = cnt; e.z = z; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic feed(input logic [3:0] d, input logic l, input logic p,
                      input logic [7:0] cnt, input logic z, input string tag);
    apply_stimulus(1'b1, d, 1'b0, l, p, cnt, z, tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
    reset    = 1'b0;
    #1;
    check_output(tag, 1'b0, 1'b0, 8'd0, 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    logic [3:0] cur;
    int         errs;
    int         nvalid;
    logic       lk;

    #3;
    check_output("reset_init", 1'b0, 1'b0, 8'd0, 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b1;

    // basic lock: seed + 4 matches
    feed(4'h1, 0, 0, 8'd0, 0, "lock_seed");
    feed(4'h2, 0, 0, 8'd0, 0, "lock_m1");
    feed(4'h4, 0, 0, 8'd0, 0, "lock_m2");
    feed(4'h9, 0, 0, 8'd0, 0, "lock_m3");
    feed(4'h3, 1, 0, 8'd0, 0, "lock_m4");

    // single zero corruption while locked
    feed(4'h6, 1, 0, 8'd0, 0, "zc_pre");
    feed(4'h0, 1, 1, 8'd1, 1, "zc_err");
    feed(4'hA, 1, 0, 8'd1, 1, "zc_post1");
    feed(4'h5, 1, 0, 8'd1, 1, "zc_post2");
    feed(4'hB, 1, 0, 8'd1, 1, "zc_post3");

    apply_stimulus(1'b0, 4'h0, 1'b1, 1, 0, 8'd0, 0, "clear_idle");

    // three consecutive misses drop lock, then relock
    feed(4'h1, 1, 1, 8'd1, 0, "loss_miss1");
    feed(4'h1, 1, 1, 8'd2, 0, "loss_miss2");
    feed(4'h1, 0, 1, 8'd3, 0, "loss_miss3");
    feed(4'h8, 0, 0, 8'd3, 0, "relock_seed");
    feed(4'h1, 0, 0, 8'd3, 0, "relock_m1");
    feed(4'h2, 0, 0, 8'd3, 0, "relock_m2");
    feed(4'h4, 0, 0, 8'd3, 0, "relock_m3");
    feed(4'h9, 1, 0, 8'd3, 0, "relock_m4");
    feed(4'h5, 1, 1, 8'd4, 0, "relock_miss");

    do_reset("reset_mid1");

    // reseed in VERIFY after two matches
    feed(4'h1, 0, 0, 8'd0, 0, "rs_seed");
    feed(4'h2, 0, 0, 8'd0, 0, "rs_m1");
    feed(4'h4, 0, 0, 8'd0, 0, "rs_m2");
    feed(4'h6, 0, 0, 8'd0, 0, "rs_reseed");
    feed(4'hD, 0, 0, 8'd0, 0, "rs_m1b");
    feed(4'hA, 0, 0, 8'd0, 0, "rs_m2b");
    feed(4'h5, 0, 0, 8'd0, 0, "rs_m3b");
    feed(4'hB, 1, 0, 8'd0, 0, "rs_m4b");

    // saturation: 100 rounds of 3 misses + resync
    cur  = 4'h7;
    errs = 0;
    for (int r = 0; r < 100; r++) begin
      for (int m = 0; m < 3; m++) begin
        errs = (errs < 255) ? errs + 1 : 255;
        feed(wrong_val(cur), (m < 2), 1'b1, 8'(errs), 1'b0, "sat_miss");
        cur = gen_next(cur);
      end
      for (int k = 0; k < 5; k++) begin
        feed(cur, (k == 4), 1'b0, 8'(errs), 1'b0, "sat_sync");
        cur = gen_next(cur);
      end
    end

    // clear priority against same-cycle increment and zero detection
    apply_stimulus(1'b1, wrong_val(cur), 1'b1, 1, 1, 8'd0, 0, "clr_miss");
    cur = gen_next(cur);
    feed(cur, 1, 0, 8'd0, 0, "clr_match");
    cur = gen_next(cur);
    feed(4'h0, 1, 1, 8'd1, 1, "clr_zero");
    cur = gen_next(cur);
    apply_stimulus(1'b1, 4'h0, 1'b1, 1, 1, 8'd0, 0, "clr_zero_clr");
    cur = gen_next(cur);
    feed(cur, 1, 0, 8'd0, 0, "clr_after");

    do_reset("reset_mid2");

    // random in_valid gaps over a correct stream
    cur    = 4'h1;
    nvalid = 0;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 99) < 30) begin
        lk = (nvalid >= 5);
        apply_stimulus(1'b0, 4'h0, 1'b0, lk, 1'b0, 8'd0, 1'b0, "gap_idle");
      end else begin
        nvalid++;
        lk = (nvalid >= 5);
        feed(cur, lk, 1'b0, 8'd0, 1'b0, "gap_valid");
        cur = gen_next(cur);
      end
    end

    do_reset("reset_mid3");

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
